// File: rtl/word_serializer_if.sv
// Upstream word stream plus serial bit stream between a word producer and the Mealy detector.
interface word_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, x, x_valid, word_done, busy
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, x, x_valid, word_done, busy
    );
endinterface

// File: rtl/word_serializer.sv
// Generic FIFO: circular buffer with synchronous flush and occupancy count.
// Latency: a word pushed at an edge is visible on rdata after that edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ws_fifo #(
    parameter int W  = 8,
    parameter int D  = 2,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Word serializer: buffers WIDTH-bit words and streams them LSB-first onto x, GAP idle cycles before each word.
// Latency: a word pushed into an empty idle block shows bit 0 on x after GAP+1 further edges.
// Backpressure: in_ready follows registered FIFO occupancy only; a pop never frees a slot in the same cycle.
module word_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    word_serializer_if.slave bus
);
    localparam int              BW       = $clog2(WIDTH);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [3:0]      GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, GAPW, SHIFT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [3:0]       gapcnt;
    logic             x_hold;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             load;
    logic             gap_ld;
    logic             fifo_nempty;
    logic             last_bit;

    assign fifo_nempty  = (count != '0);
    assign bus.in_ready = rst_n && (count < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready && !bus.abort;
    assign last_bit     = (state == SHIFT) && (bitcnt == LAST_BIT);

    ws_fifo #(
        .W  (WIDTH),
        .D  (DEPTH),
        .CW (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.abort),
        .push  (push),
        .pop   (load),
        .wdata (bus.in_data),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        gap_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nempty) begin
                    if (GAP > 0) begin
                        state_nxt = GAPW;
                        gap_ld    = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        load      = 1'b1;
                    end
                end
            end
            GAPW: begin
                if (gapcnt == '0) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (bitcnt == LAST_BIT) begin
                    if (!fifo_nempty) begin
                        state_nxt = IDLE;
                    end else if (GAP > 0) begin
                        state_nxt = GAPW;
                        gap_ld    = 1'b1;
                    end else begin
                        // back-to-back reload keeps x_valid high with no bubble
                        state_nxt = SHIFT;
                        load      = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
            load      = 1'b0;
            gap_ld    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            x_hold <= 1'b0;
        end else begin
            state <= state_nxt;
            // remember the bit on the line so x stays put while x_valid is low
            if (state == SHIFT) begin
                x_hold <= shreg[0];
            end
            if (load) begin
                shreg  <= head;
                bitcnt <= '0;
            end else if (bus.abort) begin
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
                if (bitcnt != LAST_BIT) begin
                    bitcnt <= bitcnt + BW'(1);
                end
            end
            if (gap_ld) begin
                gapcnt <= GAP_INIT;
            end else if (state == GAPW && gapcnt != '0) begin
                gapcnt <= gapcnt - 4'd1;
            end
        end
    end

    assign bus.x_valid   = (state == SHIFT);
    assign bus.word_done = last_bit;
    assign bus.x         = (state == SHIFT) ? shreg[0] : x_hold;
    assign bus.busy      = (state != IDLE) || fifo_nempty;
endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: a GAP=1 and a GAP=0 instance, each checked every cycle against a word-schedule model.
module tb_word_serializer;
    localparam int W    = 32;
    localparam int D    = 2;
    localparam int NW   = 64;
    localparam int NONE = -100000;
    localparam int GAPS [2] = '{1, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic [1:0]   in_valid_d;
    logic [W-1:0] in_data_d [2];
    logic [1:0]   o_x, o_v, o_done, o_busy, o_rdy;

    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(W)) bus_a ();
    word_serializer_if #(.WIDTH(W)) bus_b ();

    assign bus_a.in_data  = in_data_d[0];
    assign bus_a.in_valid = in_valid_d[0];
    assign bus_a.abort    = abort;
    assign bus_b.in_data  = in_data_d[1];
    assign bus_b.in_valid = in_valid_d[1];
    assign bus_b.abort    = abort;

    assign o_x    = {bus_b.x, bus_a.x};
    assign o_v    = {bus_b.x_valid, bus_a.x_valid};
    assign o_done = {bus_b.word_done, bus_a.word_done};
    assign o_busy = {bus_b.busy, bus_a.busy};
    assign o_rdy  = {bus_b.in_ready, bus_a.in_ready};

    word_serializer #(.WIDTH(W), .DEPTH(D), .GAP(1)) u_gap1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    word_serializer #(.WIDTH(W), .DEPTH(D), .GAP(0)) u_gap0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Model: every accepted word gets a start edge = max(push+GAP+1, previous start+W+GAP);
    // bit j of that word is on x in the cycle after edge start+j.
    logic [W-1:0] m_data  [2][NW];
    int           m_push  [2][NW];
    int           m_start [2][NW];
    int           m_n [2];
    int           m_lo [2];
    int           m_last [2];
    bit           m_xlast [2];
    bit           m_acc [2];
    int           t = 0;
    bit           started = 1'b0;
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic int fifo_cnt(int i, int tt);
        int c = 0;
        for (int k = m_lo[i]; k < m_n[i]; k++) begin
            if (m_start[i][k] > tt) c++;
        end
        return c;
    endfunction

    task automatic model_edge(int i, int te);
        int st;
        m_acc[i] = 1'b0;
        if (!rst_n) begin
            m_lo[i]    = m_n[i];
            m_last[i]  = NONE;
            m_xlast[i] = 1'b0;
        end else if (abort) begin
            m_lo[i]   = m_n[i];
            m_last[i] = NONE;
        end else if (in_valid_d[i] && fifo_cnt(i, te - 1) < D && m_n[i] < NW) begin
            st = te + GAPS[i] + 1;
            if (m_last[i] != NONE && m_last[i] + W + GAPS[i] > st) st = m_last[i] + W + GAPS[i];
            m_data[i][m_n[i]]  = in_data_d[i];
            m_push[i][m_n[i]]  = te;
            m_start[i][m_n[i]] = st;
            m_n[i]++;
            m_last[i] = st;
            m_acc[i]  = 1'b1;
        end
    endtask

    task automatic expect_out(int i, output bit ev, output bit ex, output bit ed, output bit eb, output bit er);
        ev = 1'b0; ex = m_xlast[i]; ed = 1'b0; eb = 1'b0;
        for (int k = m_lo[i]; k < m_n[i]; k++) begin
            if (m_push[i][k] <= t && t < m_start[i][k] + W) eb = 1'b1;
            if (m_start[i][k] <= t && t <= m_start[i][k] + W - 1) begin
                ev = 1'b1;
                ex = m_data[i][k][t - m_start[i][k]];
                ed = (t == m_start[i][k] + W - 1);
            end
        end
        er = rst_n && (fifo_cnt(i, t) < D);
    endtask

    task automatic check(string name, int i, logic act, bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %b want %b", name, i, t, act, exp);
        end
    endtask

    task automatic lit(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : cmp
        bit ev, ex, ed, eb, er;
        t = t + 1;
        for (int i = 0; i < 2; i++) model_edge(i, t);
        if (!rst_n) started = 1'b1;
        #1;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                expect_out(i, ev, ex, ed, eb, er);
                check("x_valid", i, o_v[i], ev);
                check("x", i, o_x[i], ex);
                check("word_done", i, o_done[i], ed);
                check("busy", i, o_busy[i], eb);
                check("in_ready", i, o_rdy[i], er);
                if (ev) m_xlast[i] = ex;
            end
        end
    end

    // Per-test capture of what each DUT put on the line.
    int         c_first [2];
    int         c_nv [2];
    int         c_ndone [2];
    int         c_run [2];
    int         c_maxrun [2];
    int         c_done_at [2][4];
    bit [W-1:0] c_bits [2];
    logic [W-1:0] pw [4];
    int         acc_t [2][4];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cap_clear();
        for (int i = 0; i < 2; i++) begin
            c_first[i] = NONE; c_nv[i] = 0; c_ndone[i] = 0; c_run[i] = 0; c_maxrun[i] = 0;
            c_bits[i] = '0;
            for (int k = 0; k < 4; k++) c_done_at[i][k] = 0;
        end
    endtask

    task automatic cap_sample();
        for (int i = 0; i < 2; i++) begin
            if (o_v[i]) begin
                if (c_first[i] == NONE) c_first[i] = t;
                if (c_nv[i] < W) c_bits[i][c_nv[i]] = o_x[i];
                c_nv[i]++;
                c_run[i]++;
                if (c_run[i] > c_maxrun[i]) c_maxrun[i] = c_run[i];
                if (o_done[i]) begin
                    if (c_ndone[i] < 4) c_done_at[i][c_ndone[i]] = c_nv[i];
                    c_ndone[i]++;
                end
            end else begin
                c_run[i] = 0;
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            step();
            cap_sample();
        end
    endtask

    task automatic push_words(int nwords, int budget);
        int idx [2];
        int cyc;
        idx[0] = 0; idx[1] = 0; cyc = 0;
        while ((idx[0] < nwords || idx[1] < nwords) && cyc < budget) begin
            for (int i = 0; i < 2; i++) begin
                in_valid_d[i] = (idx[i] < nwords);
                in_data_d[i]  = pw[(idx[i] < nwords) ? idx[i] : 0];
            end
            step();
            cap_sample();
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) begin
                    acc_t[i][idx[i]] = t;
                    idx[i]++;
                end
            end
            cyc++;
        end
        in_valid_d = 2'b00;
        lit("push_count_gap1", idx[0], nwords);
        lit("push_count_gap0", idx[1], nwords);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_lo[i] = 0; m_last[i] = NONE; m_xlast[i] = 1'b0; m_acc[i] = 1'b0;
            in_data_d[i] = '0;
        end
        rst_n = 1'b0; abort = 1'b0; in_valid_d = 2'b00;

        // reset state
        step();
        step();
        lit("rst_x_valid", o_v, 0);
        lit("rst_x", o_x, 0);
        lit("rst_busy", o_busy, 0);
        lit("rst_in_ready_low", o_rdy, 0);
        rst_n = 1'b1;
        step();
        lit("in_ready_after_rst", o_rdy, 3);

        // single word, latency and bit order
        cap_clear();
        pw[0] = 32'h66DBDF7F;
        push_words(1, 4);
        e = acc_t[0][0];
        lit("t1_same_push_edge", acc_t[1][0], e);
        run(40);
        lit("t1_first_valid_gap1", c_first[0], e + 2);
        lit("t1_first_valid_gap0", c_first[1], e + 1);
        lit("t1_first16_bits", c_bits[0][15:0], 16'hDF7F);
        lit("t1_word_bits", c_bits[0], 32'h66DBDF7F);
        lit("t1_done_at_bit", c_done_at[0][0], 32);
        lit("t1_done_count", c_ndone[0], 1);
        lit("t1_idle_busy", o_busy, 0);

        // three words with in_valid held: full FIFO, pop while full
        cap_clear();
        pw[0] = 32'h66DBDF7F; pw[1] = 32'h557FD741; pw[2] = 32'h54C52B45;
        push_words(3, 10);
        lit("t2_second_push_gap1", acc_t[0][1] - acc_t[0][0], 1);
        lit("t2_third_push_gap1", acc_t[0][2] - acc_t[0][0], 3);
        lit("t2_third_push_gap0", acc_t[1][2] - acc_t[1][0], 2);
        run(110);
        lit("t2_valid_cycles_gap1", c_nv[0], 96);
        lit("t2_done_count_gap1", c_ndone[0], 3);
        lit("t2_longest_run_gap1", c_maxrun[0], 32);
        lit("t2_third_done_gap1", c_done_at[0][2], 96);
        lit("t2_longest_run_gap0", c_maxrun[1], 96);

        // GAP=0 back-to-back
        cap_clear();
        pw[0] = 32'hA5A50F0F; pw[1] = 32'h92345678;
        push_words(2, 6);
        run(80);
        lit("t3_run_gap0", c_maxrun[1], 64);
        lit("t3_done1_gap0", c_done_at[1][0], 32);
        lit("t3_done2_gap0", c_done_at[1][1], 64);
        lit("t3_run_gap1", c_maxrun[0], 32);
        lit("t3_x_holds_msb", o_x, 3);

        // abort at bit 10 of word 1 with word 2 buffered, push on the abort edge dropped
        cap_clear();
        pw[0] = 32'h0F0F3C3C; pw[1] = 32'hFFFF0001;
        push_words(2, 6);
        e = acc_t[0][0];
        while (t < e + 12) begin
            step();
            cap_sample();
        end
        lit("t4_bits_before_abort_gap1", c_nv[0], 11);
        abort = 1'b1;
        in_valid_d = 2'b11;
        in_data_d[0] = 32'hDEADBEEF;
        in_data_d[1] = 32'hDEADBEEF;
        step();
        cap_sample();
        abort = 1'b0;
        in_valid_d = 2'b00;
        lit("t4_abort_x_valid", o_v, 0);
        lit("t4_abort_busy", o_busy, 0);
        lit("t4_abort_in_ready", o_rdy, 3);
        run(40);
        lit("t4_no_done", c_ndone[0] + c_ndone[1], 0);
        lit("t4_frozen_gap1", c_nv[0], 11);
        lit("t4_frozen_gap0", c_nv[1], 12);
        cap_clear();
        pw[0] = 32'h00000003;
        push_words(1, 4);
        e = acc_t[0][0];
        run(40);
        lit("t4_later_first_gap1", c_first[0], e + 2);
        lit("t4_later_done_gap1", c_ndone[0], 1);

        // reset mid-word
        cap_clear();
        pw[0] = 32'hFFFFFFFF;
        push_words(1, 4);
        run(6);
        rst_n = 1'b0;
        step();
        lit("t5_rst_x", o_x, 0);
        lit("t5_rst_x_valid", o_v, 0);
        lit("t5_rst_busy", o_busy, 0);
        lit("t5_rst_done", o_done, 0);
        rst_n = 1'b1;
        cap_clear();
        run(40);
        lit("t5_no_leftover_bits", c_nv[0] + c_nv[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Upstream feeder for the serial Mealy detector (`mealy`). It replaces the behavioural stimulus loop with synthesizable RTL.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Streams each word LSB-first onto the single-bit `x` line, one bit per `clk`.
- Inserts GAP idle cycles before every word, and flags bit validity and word completion for the consumer.

Parameters:
- WIDTH, 32, bits per word. Legal range 2..64.
- DEPTH, 2, FIFO entries. Legal range 1..8.
- GAP, 1, minimum idle cycles with x_valid=0 before each word. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- abort  input  1  synchronous flush; drops the word in flight and all buffered words.
- x  output  1  serial bit to the detector.
- x_valid  output  1  x carries a real data bit this cycle.
- word_done  output  1  one-cycle pulse marking the last bit of a word.
- busy  output  1  high when state≠IDLE or FIFO non-empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports named `clk`, `rst_n`). All state changes on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE; FIFO count=0; bit counter=0; gap counter=0.
  - Outputs: x=0, x_valid=0, word_done=0, busy=0.
  - in_ready=1 from the first cycle after the reset edge.
  - A reset mid-word discards the word and all buffered words, with no partial-word completion.
- Handshake:
  - A push occurs at an edge where in_valid=1 and in_ready=1.
  - in_ready = (count<DEPTH) and rst_n=1. It is a function of registered count only, never of a same-cycle pop.
  - When full, in_ready=0 even if a pop occurs that edge.
  - Push and pop on the same edge: count unchanged; FIFO order preserved.
- FSM states: IDLE, GAPW, SHIFT.
  - IDLE, FIFO non-empty: if GAP>0, go to GAPW with gap counter=GAP-1; if GAP=0, load the shift register from the FIFO head, pop, and go to SHIFT.
  - GAPW: decrement the gap counter each cycle. When it reaches 0, load the FIFO head, pop, set bit counter=0, and go to SHIFT.
  - SHIFT: x=shreg[0] and x_valid=1. Each edge shifts right and increments the bit counter.
  - SHIFT, bit counter=WIDTH-1: word_done=1 this cycle. At the next edge:
    - FIFO non-empty: go to GAPW, or straight to a fresh SHIFT load when GAP=0 (back-to-back, no bubble).
    - FIFO empty: go to IDLE.
- Latency: a word pushed at edge E into an empty, IDLE block has bit 0 on x after edge E+GAP+1.
  - WIDTH bits follow on consecutive cycles.
  - Between words, x_valid is low for exactly GAP cycles when the FIFO never runs dry.
- x when x_valid=0: holds the last driven bit (0 after reset). The consumer must qualify x with x_valid.
- abort (rst_n=1, abort=1 at an edge):
  - FIFO cleared; state=IDLE; x_valid=0; word_done=0; x holds.
  - A push requested on the same edge is dropped; in_ready reads 1 in the following cycle.
- Counters: bit counter is ceil(log2(WIDTH)) bits and never wraps past WIDTH-1. FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, then push 32'h66DBDF7F (GAP=1) at edge E → x_valid rises after E+2; x sequence 1,1,1,1,1,1,1,0,1,1,1,1,1,0,1,1,…; word_done high exactly in the 32nd valid cycle; then IDLE with busy=0.
- Push 32'h66DBDF7F, 32'h557FD741, 32'h54C52B45 back-to-back with in_valid held → in_ready drops after 2 pushes; third accepted when first word starts shifting; 3 words emitted in order, each preceded by exactly 1 x_valid=0 cycle.
- GAP=0, two words queued → 64 consecutive x_valid=1 cycles; word_done pulses at cycles 32 and 64.
- abort asserted at bit 10 of word 1 with word 2 buffered → next cycle x_valid=0, busy=0, in_ready=1; no word_done pulse; a later word emits normally after GAP+1 cycles.
- rst_n=0 for one cycle mid-word → next cycle all outputs at reset values; the remaining bits are never emitted.
- Full FIFO with in_valid=1 held while a pop occurs → no push on that edge; push accepted on the following edge; no word lost or duplicated (scoreboard check).
